// File: rtl/clock_gate_node_multi.sv
// clock_gate_node_multi: multi-child clock gating node; ports clock/sync_reset, parent req/ready/silent, per-child req/ready/silent/starting/stopping, gated clocks, node_state
module clock_gate_node_multi #(
  parameter int NUM_CHILDREN = 4,
  parameter int START_DELAY  = 2,
  parameter int STOP_DELAY   = 8
) (
  input  logic                    clock,
  input  logic                    sync_reset,
  output logic                    parent_request,
  input  logic                    parent_ready,
  input  logic                    parent_silent,
  input  logic [NUM_CHILDREN-1:0] child_request,
  output logic [NUM_CHILDREN-1:0] child_ready,
  output logic [NUM_CHILDREN-1:0] child_silent,
  output logic [NUM_CHILDREN-1:0] child_starting,
  output logic [NUM_CHILDREN-1:0] child_stopping,
  input  logic                    clock_route_path_in,
  output logic [NUM_CHILDREN-1:0] clock_route_path_out,
  output logic [2:0]              node_state
);
  localparam int MAXD = START_DELAY > STOP_DELAY ? START_DELAY : STOP_DELAY;
  localparam int CW   = MAXD > 0 ? $clog2(MAXD + 1) : 1;
  typedef enum logic [2:0] {OFF, UP, SETTLE, ON, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_CHILDREN-1:0] en, en_n, starting, start_n, stopping, stop_n, en_lat;
  logic any_req, lost, run;
  assign any_req = |child_request;
  assign lost    = !parent_ready || parent_silent;
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state    <= OFF;
      cnt      <= '0;
      en       <= '0;
      starting <= '0;
      stopping <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      en       <= en_n;
      starting <= start_n;
      stopping <= stop_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      OFF:    if (any_req) state_n = UP;
      UP:     if (!lost) begin
                state_n = START_DELAY == 0 ? ON : SETTLE;
                cnt_n   = START_DELAY == 0 ? '0 : CW'(START_DELAY - 1);
              end
      SETTLE: if (lost) state_n = UP;
              else if (cnt == '0) state_n = ON;
              else cnt_n = cnt - 1'b1;
      ON:     if (lost) state_n = any_req ? UP : DRAIN;
              else if (!any_req && en == '0) begin
                state_n = STOP_DELAY == 0 ? DRAIN : HOLD;
                cnt_n   = STOP_DELAY == 0 ? '0 : CW'(STOP_DELAY - 1);
              end
      HOLD:   if (lost) state_n = any_req ? UP : DRAIN;
              else if (any_req) begin
                state_n = ON;
                cnt_n   = '0;
              end else if (cnt == '0) state_n = DRAIN;
              else cnt_n = cnt - 1'b1;
      DRAIN:  if (!parent_ready) state_n = OFF;
      default: state_n = OFF;
    endcase
  end
  always_comb begin
    run            = state == ON && !lost;
    en_n           = run ? child_request : '0;
    start_n        = run ? child_request & ~en : '0;
    stop_n         = run ? ~child_request & en : en;
    parent_request = state == UP || state == SETTLE || state == ON || state == HOLD;
    child_ready    = en & ~starting;
    child_starting = starting;
    child_stopping = stopping;
    child_silent   = ~(en | starting | stopping);
    node_state     = state;
  end
  always_latch if (!clock_route_path_in) en_lat <= en;
  assign clock_route_path_out = {NUM_CHILDREN{clock_route_path_in}} & en_lat;
endmodule

// File: doc/clock_gate_node_multi.md
Name: clock_gate_node_multi

Overview:
- Parametrised successor to the single-child clock gating node used in daisy-chained clock trees.
- One node serves NUM_CHILDREN independent child request/ready channels and aggregates them into one parent request.
- Adds a start settle delay and a stop hysteresis counter, so brief request gaps do not toggle the parent.
- Drives one glitch-free gated copy of clock_route_path_in per child.

Parameters:
NUM_CHILDREN, 4, number of child channels (1..16)
START_DELAY, 2, cycles between parent_ready rising and the node becoming ON (0 allowed)
STOP_DELAY, 8, idle cycles with all child requests low before the parent request drops (0 allowed)

Ports:
clock  in  1  control clock; all state registers clock on its rising edge
sync_reset  in  1  synchronous reset, active-high
parent_request  out  1  request to the upstream node
parent_ready  in  1  upstream node grants a running clock
parent_silent  in  1  upstream node's clock is stopped; forces loss of service
child_request  in  NUM_CHILDREN  per-child clock request
child_ready  out  NUM_CHILDREN  per-child gated clock is running
child_silent  out  NUM_CHILDREN  per-child gated clock is stopped and idle
child_starting  out  NUM_CHILDREN  one-cycle pulse when the child's gate opens
child_stopping  out  NUM_CHILDREN  one-cycle pulse when the child's gate closes
clock_route_path_in  in  1  clock to be distributed
clock_route_path_out  out  NUM_CHILDREN  gated clocks, one per child
node_state  out  3  FSM state: OFF=0, UP=1, SETTLE=2, ON=3, HOLD=4, DRAIN=5

Behaviour:
- Reset is synchronous and active-high. With sync_reset=1 at a clock edge:
  - state=OFF, counter=0, en[]=0, parent_request=0, child_ready=0, child_starting=0, child_stopping=0, child_silent=all 1.
- Reset mid-operation closes all gates on that edge. No stopping pulses are emitted.
- Define any_req = |child_request and lost = !parent_ready | parent_silent.
- FSM:
  - OFF: parent_request=0. If any_req, go to UP.
  - UP: parent_request=1. When parent_ready & !parent_silent:
    - START_DELAY=0: go to ON.
    - Otherwise: go to SETTLE with counter=START_DELAY-1.
  - SETTLE: parent_request=1. Counter decrements each cycle; at 0, go to ON. If lost, go back to UP.
  - ON: parent_request=1. Per child i, evaluated each cycle:
    - en[i]=0 & child_request[i]=1: next cycle en[i]=1 and child_starting[i]=1; the cycle after, child_ready[i]=1.
    - en[i]=1 & child_request[i]=0: next cycle en[i]=0 and child_stopping[i]=1 (child_ready[i] drops in the same cycle); the cycle after, child_silent[i]=1.
    - If !any_req and all en=0:
      - STOP_DELAY=0: go to DRAIN.
      - Otherwise: go to HOLD with counter=STOP_DELAY-1.
  - HOLD: parent_request=1 and all gates closed. Counter decrements each cycle.
    - If any_req: return to ON. The parent is not re-handshaken and the counter is cleared.
    - If counter=0 and !any_req: go to DRAIN.
  - DRAIN: parent_request=0. When parent_ready=0, go to OFF. A request arriving in DRAIN is held until OFF, then goes to UP.
- Loss of service: if lost while in ON or HOLD:
  - Every en[i]=1 clears on the next cycle with child_stopping[i]=1.
  - The state goes to UP if any_req, otherwise to DRAIN.
- child_silent[i] = !en[i] & !child_starting[i] & !child_stopping[i]. child_ready, child_starting, child_stopping and child_silent are mutually exclusive per bit.
- Simultaneous rise/fall on different children in the same cycle are handled independently.
- A request pulse of one cycle in ON still produces one starting pulse followed by one stopping pulse, with no cycle of overlap.
- Gating:
  - clock_route_path_out[i] = clock_route_path_in AND a latch of en[i].
  - The latch is transparent while clock_route_path_in is low, so each gate has no glitches or runt pulses.
  - This is the only logic outside the clock domain.
- Counter width is clog2(max(START_DELAY, STOP_DELAY)+1).

Test Plan (NUM_CHILDREN=4, START_DELAY=2, STOP_DELAY=8, parent_ready tied to parent_request delayed by 1 cycle, parent_silent=0):
- Reset with child_request=4'b0000 -> node_state=0, parent_request=0, child_silent=4'b1111, every clock_route_path_out low.
- child_request=4'b0001 from OFF -> parent_request at +1, state UP→SETTLE, 2 settle cycles, ON; then child_starting=4'b0001 for 1 cycle and child_ready[0]=1 on the next cycle; out[0] toggles without runt pulses.
- Drop child_request[0], then re-raise it 5 cycles later -> HOLD, then back to ON; parent_request stays 1 throughout; one stopping pulse and one starting pulse.
- Drop child_request[0] and keep it low -> child_stopping pulse, 8 HOLD cycles, DRAIN, parent_request=0, OFF after parent_ready falls.
- child_request 4'b0101 → 4'b1010 in one cycle while ON -> in the same cycle child_stopping=4'b0101 and child_starting=4'b1010; parent_request never drops.
- parent_silent=1 while children 0 and 2 are enabled -> child_stopping=4'b0101 next cycle, state=UP; after recovery (parent_silent back to 0) children restart via SETTLE; separately, a sync_reset pulse mid-ON -> all outputs at reset values on that edge.
